// File: rtl/copper_fetch.sv
// Copper instruction fetch: pairs even/odd memory halves into 32-bit words behind a 2-entry prefetch buffer.
// Optional starvation counter on stall_count_o is built when COPPER_FETCH_STATS_EN is defined.
module copper_fetch #(
   parameter int AWIDTH = 10
) (
   input  logic              clk,
   input  logic              reset_n_i,
   input  logic              en_i,
   input  logic              restart_i,
   input  logic              jump_i,
   input  logic [AWIDTH-1:0] jump_addr_i,
   output logic              mem_rd_en_o,
   output logic [AWIDTH-1:0] mem_rd_addr_o,
   input  logic [15:0]       even_data_i,
   input  logic [15:0]       odd_data_i,
   output logic              instr_valid_o,
   output logic [31:0]       instr_o,
   output logic [AWIDTH-1:0] instr_pc_o,
   input  logic              instr_ready_i,
   output logic [15:0]       stall_count_o
);

   logic [AWIDTH-1:0] pc;
   logic [1:0]        count;
   logic              inflight;
   logic [31:0]       head_instr;
   logic [31:0]       tail_instr;
   logic [AWIDTH-1:0] head_pc;
   logic [AWIDTH-1:0] tail_pc;

   logic              pop;
   logic              flush;
   logic              issue;
   logic [2:0]        occ_after_pop;
   logic [31:0]       fetched_instr;
   logic [AWIDTH-1:0] fetched_pc;

   assign instr_valid_o = (count != 2'd0);
   assign instr_o       = head_instr;
   assign instr_pc_o    = head_pc;

   assign pop           = instr_valid_o & instr_ready_i;
   assign flush         = restart_i | jump_i;
   assign occ_after_pop = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
   assign issue         = en_i & ~flush & (occ_after_pop < 3'd2);

   // Gated by reset so the memories see no read while the block is held in reset.
   assign mem_rd_en_o   = issue & reset_n_i;
   assign mem_rd_addr_o = pc;

   // pc advanced exactly once since the in-flight read, and any flush drops that read.
   assign fetched_instr = {even_data_i, odd_data_i};
   assign fetched_pc    = pc - 1'b1;

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         pc         <= '0;
         count      <= 2'd0;
         inflight   <= 1'b0;
         head_instr <= '0;
         tail_instr <= '0;
         head_pc    <= '0;
         tail_pc    <= '0;
      end else if (flush) begin
         pc       <= restart_i ? '0 : jump_addr_i;
         count    <= 2'd0;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc <= pc + 1'b1;
         end
         case ({inflight, pop})
            2'b10: begin
               assert (count != 2'd2);
               if (count == 2'd0) begin
                  head_instr <= fetched_instr;
                  head_pc    <= fetched_pc;
               end else begin
                  tail_instr <= fetched_instr;
                  tail_pc    <= fetched_pc;
               end
               count <= count + 1'b1;
            end
            2'b01: begin
               head_instr <= tail_instr;
               head_pc    <= tail_pc;
               count      <= count - 1'b1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  head_instr <= fetched_instr;
                  head_pc    <= fetched_pc;
               end else begin
                  head_instr <= tail_instr;
                  head_pc    <= tail_pc;
                  tail_instr <= fetched_instr;
                  tail_pc    <= fetched_pc;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef COPPER_FETCH_STATS_EN
   logic [15:0] stall_count;

   // Counts cycles the execute unit wanted an instruction but none was ready; jumps keep the tally.
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         stall_count <= 16'd0;
      end else if (restart_i) begin
         stall_count <= 16'd0;
      end else if (en_i && instr_ready_i && !instr_valid_o && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'd1;
      end
   end

   assign stall_count_o = stall_count;
`else
   assign stall_count_o = 16'd0;
`endif

endmodule

// File: tb/tb_copper_fetch.sv
// Testbench for copper_fetch: queue-based reference model checked every cycle, directed scenarios, random traffic.
module tb_copper_fetch;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          en = 1'b0;
   logic          restart = 1'b0;
   logic          jump = 1'b0;
   logic [AW-1:0] jump_addr = '0;
   logic          mem_rd_en_o;
   logic [AW-1:0] mem_rd_addr_o;
   logic [15:0]   even_data = 16'd0;
   logic [15:0]   odd_data = 16'd0;
   logic          instr_valid_o;
   logic [31:0]   instr_o;
   logic [AW-1:0] instr_pc_o;
   logic          ready = 1'b0;
   logic [15:0]   stall_count_o;

   logic [31:0]   mem [0:(1<<AW)-1];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   copper_fetch #(.AWIDTH(AW)) dut (
      .clk           (clk),
      .reset_n_i     (reset_n),
      .en_i          (en),
      .restart_i     (restart),
      .jump_i        (jump),
      .jump_addr_i   (jump_addr),
      .mem_rd_en_o   (mem_rd_en_o),
      .mem_rd_addr_o (mem_rd_addr_o),
      .even_data_i   (even_data),
      .odd_data_i    (odd_data),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_ready_i (ready),
      .stall_count_o (stall_count_o)
   );

   // Paired memory halves with one cycle of read latency.
   always @(posedge clk) begin
      if (mem_rd_en_o) begin
         even_data <= mem[mem_rd_addr_o][31:16];
         odd_data  <= mem[mem_rd_addr_o][15:0];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: the buffer is a queue of {pc, instr}; the read issued last cycle lands at its tail.
   logic [AW+31:0] m_buf [$];
   logic [AW-1:0]  m_pc = '0;
   logic [AW-1:0]  m_infl_addr = '0;
   bit             m_inflight = 1'b0;
   int             m_stall = 0;

   always @(negedge clk) begin : compare_proc
      bit pop;
      bit exp_en;
      int occ;
      if (!reset_n) begin
         m_buf.delete();
         m_pc       = '0;
         m_inflight = 1'b0;
         m_stall    = 0;
         checkOutput("reset_valid", 32'(instr_valid_o), 32'd0);
         checkOutput("reset_instr", instr_o, 32'd0);
         checkOutput("reset_pc", 32'(instr_pc_o), 32'd0);
         checkOutput("reset_rd_en", 32'(mem_rd_en_o), 32'd0);
         checkOutput("reset_rd_addr", 32'(mem_rd_addr_o), 32'd0);
         checkOutput("reset_stall", 32'(stall_count_o), 32'd0);
      end else begin
         pop    = (m_buf.size() > 0) && ready;
         occ    = m_buf.size() + int'(m_inflight) - int'(pop);
         exp_en = en && !restart && !jump && (occ < 2);
         checkOutput("rd_en", 32'(mem_rd_en_o), 32'(exp_en));
         if (exp_en) checkOutput("rd_addr", 32'(mem_rd_addr_o), 32'(m_pc));
         checkOutput("valid", 32'(instr_valid_o), 32'(m_buf.size() > 0));
         if (m_buf.size() > 0) begin
            checkOutput("instr", instr_o, m_buf[0][31:0]);
            checkOutput("instr_pc", 32'(instr_pc_o), 32'(m_buf[0][AW+31:32]));
         end
`ifdef COPPER_FETCH_STATS_EN
         checkOutput("stall_count", 32'(stall_count_o), 32'(m_stall));
`else
         checkOutput("stall_count", 32'(stall_count_o), 32'd0);
`endif
         if (restart) m_stall = 0;
         else if (en && ready && (m_buf.size() == 0) && (m_stall < 65535)) m_stall++;
         if (restart || jump) begin
            m_buf.delete();
            m_inflight = 1'b0;
            m_pc       = restart ? '0 : jump_addr;
         end else begin
            if (pop) void'(m_buf.pop_front());
            if (m_inflight) m_buf.push_back({m_infl_addr, mem[m_infl_addr]});
            m_inflight = exp_en;
            if (exp_en) begin
               m_infl_addr = m_pc;
               m_pc        = m_pc + 1'b1;
            end
         end
      end
   end

   task automatic applyStimulus(input bit e, input bit r, input bit j, input logic [AW-1:0] ja, input bit rdy);
      @(posedge clk);
      #1;
      en        = e;
      restart   = r;
      jump      = j;
      jump_addr = ja;
      ready     = rdy;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin : stimulus
      logic [31:0] exp_seq [4];
      int reads;
      exp_seq = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
      for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[i] = exp_seq[i];
      mem[10'h200] = 32'hCAFE_0200;

      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Restart with ready held: first word two cycles after the restart edge, then one per cycle.
      applyStimulus(1, 1, 0, '0, 1);
      applyStimulus(1, 0, 0, '0, 1);
      settle();
      checkOutput("t1_valid_lat1", 32'(instr_valid_o), 32'd0);
      applyStimulus(1, 0, 0, '0, 1);
      settle();
      checkOutput("t1_valid_lat2", 32'(instr_valid_o), 32'd0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1, 0, 0, '0, 1);
         settle();
         checkOutput("t1_valid", 32'(instr_valid_o), 32'd1);
         checkOutput("t1_instr", instr_o, exp_seq[k]);
         checkOutput("t1_pc", 32'(instr_pc_o), k);
`ifdef COPPER_FETCH_STATS_EN
         if (k == 0) checkOutput("t1_stall", 32'(stall_count_o), 32'd2);
`else
         if (k == 0) checkOutput("t1_stall", 32'(stall_count_o), 32'd0);
`endif
      end

      // Restart with ready low: exactly two reads fill the buffer, head holds.
      applyStimulus(1, 1, 0, '0, 0);
      reads = 0;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1, 0, 0, '0, 0);
         settle();
         reads += int'(mem_rd_en_o);
      end
      checkOutput("t2_reads", reads, 32'd2);
      checkOutput("t2_rd_en_full", 32'(mem_rd_en_o), 32'd0);
      checkOutput("t2_hold_instr", instr_o, 32'h1111_2222);
      applyStimulus(1, 0, 0, '0, 1);
      settle();
      checkOutput("t2_pop_instr", instr_o, 32'h1111_2222);
      applyStimulus(1, 0, 0, '0, 1);
      settle();
      checkOutput("t2_next_valid", 32'(instr_valid_o), 32'd1);
      checkOutput("t2_next_instr", instr_o, 32'h3333_4444);
      checkOutput("t2_next_pc", 32'(instr_pc_o), 32'd1);

      // Fill the buffer, then jump with an accept in the same cycle.
      for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, '0, 0);
      settle();
      checkOutput("t3_full_pc", 32'(instr_pc_o), 32'd2);
      checkOutput("t3_full_rd_en", 32'(mem_rd_en_o), 32'd0);
      applyStimulus(1, 0, 1, 10'h200, 1);
      applyStimulus(1, 0, 0, '0, 1);
      settle();
      checkOutput("t3_flush_valid", 32'(instr_valid_o), 32'd0);
      checkOutput("t3_rd_en", 32'(mem_rd_en_o), 32'd1);
      checkOutput("t3_rd_addr", 32'(mem_rd_addr_o), 32'h200);
      applyStimulus(1, 0, 0, '0, 1);
      settle();
      checkOutput("t3_valid_gap", 32'(instr_valid_o), 32'd0);
      applyStimulus(1, 0, 0, '0, 1);
      settle();
      checkOutput("t3_target_pc", 32'(instr_pc_o), 32'h200);
      checkOutput("t3_target_instr", instr_o, 32'hCAFE_0200);

      // Free-running across the top of the address space.
      applyStimulus(1, 0, 1, 10'h3FE, 1);
      applyStimulus(1, 0, 0, '0, 1);
      applyStimulus(1, 0, 0, '0, 1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, 0, 0, '0, 1);
         settle();
         checkOutput("t4_wrap_pc", 32'(instr_pc_o), (32'h3FE + k) % 32'h400);
      end

      // Asynchronous reset during sustained fetch.
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      en      = 1'b0;
      settle();
      checkOutput("t5_valid", 32'(instr_valid_o), 32'd0);
      checkOutput("t5_instr", instr_o, 32'd0);
      checkOutput("t5_rd_en", 32'(mem_rd_en_o), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 0, 0, '0, 1);
         settle();
         checkOutput("t5_idle_valid", 32'(instr_valid_o), 32'd0);
      end

      // Random traffic, including occasional single-cycle resets.
      for (int k = 0; k < 3000; k++) begin
         applyStimulus(($urandom % 8) != 0, ($urandom % 64) == 0, ($urandom % 32) == 0,
                       AW'($urandom), ($urandom % 4) != 0);
         reset_n = ($urandom_range(0, 399) != 0);
      end
      applyStimulus(0, 0, 0, '0, 0);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
